// File: rtl/psram_responder_pkg.sv
// Shared constants and FSM state type for the PSRAM device-side responder.
package psram_responder_pkg;

    // Controller samples read data at this OE-low cycle; READ_LATENCY must stay below it.
    localparam int unsigned REQUIRED_CYCLES       = 4;
    localparam int unsigned DEFAULT_READ_LATENCY  = 2;
    localparam int unsigned DEFAULT_MIN_WE_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WRITE_PULSE = 2'd1,
        ST_READ_ACCESS = 2'd2,
        ST_READ_VALID  = 2'd3
    } state_t;

endpackage

// File: rtl/psram_mem.sv
// Single-port 2^ADDR_BITS x 16 synchronous RAM with byte-write enables and registered read.
module psram_mem #(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 CLK,
    input  logic [ADDR_BITS-1:0] ADDR,
    input  logic [15:0]          WDATA,
    input  logic [1:0]           BE,
    output logic [15:0]          RDATA
);

    logic [15:0] mem [0:(1 << ADDR_BITS)-1];

    always_ff @(posedge CLK) begin
        if (BE[0]) mem[ADDR][7:0]  <= WDATA[7:0];
        if (BE[1]) mem[ADDR][15:8] <= WDATA[15:8];
        RDATA <= mem[ADDR];
    end

endmodule

// File: rtl/psram_responder.sv
// Device-side model of an asynchronous-mode PSRAM: samples the bus every CLK,
// commits byte-enabled writes, returns reads after READ_LATENCY, flags protocol violations.
module psram_responder
    import psram_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = 10,
    parameter int unsigned READ_LATENCY  = DEFAULT_READ_LATENCY,
    parameter int unsigned MIN_WE_CYCLES = DEFAULT_MIN_WE_CYCLES
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_X,
    input  logic        OE_X,
    input  logic        WE_X,
    input  logic        LB_X,
    input  logic        UB_X,
    input  logic [22:0] A_IN,
    inout  logic [15:0] DQ,
    output logic        WR_DONE,
    output logic        RD_DONE,
    output logic        ERR
);

    localparam logic [3:0] RL_C     = 4'(READ_LATENCY);
    localparam logic [3:0] MIN_WE_C = 4'(MIN_WE_CYCLES);

    state_t               state;
    logic [3:0]           cnt;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [15:0]          wr_data;
    logic                 wr_lb_x;
    logic                 wr_ub_x;
    logic                 dq_oe;
    logic                 rd_lb_x;
    logic                 rd_ub_x;

    logic                 we_low;
    logic                 rd_low;
    logic                 commit;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [15:0]          mem_wdata;
    logic [1:0]           mem_be;
    logic [15:0]          mem_rdata;
    logic                 unused_addr_bits;

    assign unused_addr_bits = &{1'b0, A_IN[22:ADDR_BITS]};

    assign we_low = !CE_X && !WE_X;
    assign rd_low = !CE_X && !OE_X;
    // The edge that sees the write pulse end is the commit edge; reset on that edge wins.
    assign commit = !RST && (state == ST_WRITE_PULSE) && !we_low && (cnt >= MIN_WE_C);

    always_comb begin
        mem_be    = '0;
        mem_addr  = A_IN[ADDR_BITS-1:0];
        mem_wdata = wr_data;
        if (commit) begin
            mem_be   = {~wr_ub_x, ~wr_lb_x};
            mem_addr = wr_addr;
        end
    end

    psram_mem #(
        .ADDR_BITS(ADDR_BITS)
    ) u_mem (
        .CLK   (CLK),
        .ADDR  (mem_addr),
        .WDATA (mem_wdata),
        .BE    (mem_be),
        .RDATA (mem_rdata)
    );

    assign DQ = dq_oe ? {rd_ub_x ? 8'h00 : mem_rdata[15:8],
                         rd_lb_x ? 8'h00 : mem_rdata[7:0]} : 'z;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            dq_oe   <= 1'b0;
            WR_DONE <= 1'b0;
            RD_DONE <= 1'b0;
            ERR     <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_lb_x <= 1'b1;
            wr_ub_x <= 1'b1;
            rd_lb_x <= 1'b1;
            rd_ub_x <= 1'b1;
        end else begin
            WR_DONE <= commit;
            RD_DONE <= 1'b0;
            rd_lb_x <= LB_X;
            rd_ub_x <= UB_X;

            // Every write-low cycle captures the sample; the closing cycle never does.
            if (we_low) begin
                wr_addr <= A_IN[ADDR_BITS-1:0];
                wr_data <= DQ;
                wr_lb_x <= LB_X;
                wr_ub_x <= UB_X;
            end
            if (we_low && !OE_X) ERR <= 1'b1;

            unique case (state)
                ST_IDLE: begin
                    if (we_low) begin
                        state <= ST_WRITE_PULSE;
                        cnt   <= 4'd1;
                    end else if (rd_low) begin
                        cnt <= 4'd1;
                        if (RL_C == 4'd1) begin
                            state   <= ST_READ_VALID;
                            dq_oe   <= 1'b1;
                            RD_DONE <= 1'b1;
                        end else begin
                            state <= ST_READ_ACCESS;
                        end
                    end
                end
                ST_WRITE_PULSE: begin
                    if (we_low) begin
                        if (cnt != 4'd15) cnt <= cnt + 4'd1;
                    end else begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        if (cnt < MIN_WE_C) ERR <= 1'b1;
                    end
                end
                ST_READ_ACCESS: begin
                    if (we_low) begin
                        ERR   <= 1'b1;
                        state <= ST_WRITE_PULSE;
                        cnt   <= 4'd1;
                    end else if (!rd_low) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt + 4'd1 >= RL_C) begin
                        state   <= ST_READ_VALID;
                        cnt     <= cnt + 4'd1;
                        dq_oe   <= 1'b1;
                        RD_DONE <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_READ_VALID: begin
                    if (we_low) begin
                        ERR   <= 1'b1;
                        state <= ST_WRITE_PULSE;
                        cnt   <= 4'd1;
                        dq_oe <= 1'b0;
                    end else if (!rd_low) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        dq_oe <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    dq_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psram_responder.sv
// Self-checking bench for psram_responder: a controller model drives the bus, a memory
// model and an expected-read queue supply every reference value.
module tb_psram_responder;

    localparam int unsigned RL       = 2;
    localparam int unsigned MINW     = 2;
    localparam logic [15:0] RELEASED = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_x, oe_x, we_x, lb_x, ub_x;
    logic [22:0] a_in;
    logic [15:0] tb_dq;
    logic        tb_oe;
    wire  [15:0] dq;
    wire         wr_done, rd_done, err;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] model [0:1023];
    logic [15:0] exp_q [$];
    logic        exp_err;

    assign dq = tb_oe ? tb_dq : 'z;
    for (genvar g = 0; g < 16; g++) begin : g_pull
        pullup (dq[g]);
    end

    always #5 clk = ~clk;

    psram_responder #(
        .ADDR_BITS     (10),
        .READ_LATENCY  (RL),
        .MIN_WE_CYCLES (MINW)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .CE_X    (ce_x),
        .OE_X    (oe_x),
        .WE_X    (we_x),
        .LB_X    (lb_x),
        .UB_X    (ub_x),
        .A_IN    (a_in),
        .DQ      (dq),
        .WR_DONE (wr_done),
        .RD_DONE (rd_done),
        .ERR     (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        ce_x  = 1'b1;
        oe_x  = 1'b1;
        we_x  = 1'b1;
        lb_x  = 1'b0;
        ub_x  = 1'b0;
        tb_oe = 1'b0;
    endtask

    task automatic do_write(input logic [22:0] addr, input logic [15:0] data,
                            input logic lb, input logic ub, input logic oe, input int n);
        logic ok;
        ce_x = 1'b0; we_x = 1'b0; oe_x = oe;
        a_in = addr; tb_dq = data; tb_oe = 1'b1; lb_x = lb; ub_x = ub;
        for (int i = 0; i < n; i++) begin
            tick();
            checks++;
            if (wr_done !== 1'b0) begin
                errors++; $display("FAIL wr_done_early: got %b expected 0", wr_done);
            end
        end
        ce_x = 1'b1; we_x = 1'b1; oe_x = 1'b1; tb_oe = 1'b0;
        tick();
        ok = (n >= MINW);
        checks++;
        if (wr_done !== ok) begin
            errors++; $display("FAIL wr_done: addr %h got %b expected %b", addr, wr_done, ok);
        end
        if (ok) begin
            if (!lb) model[addr[9:0]][7:0]  = data[7:0];
            if (!ub) model[addr[9:0]][15:8] = data[15:8];
        end else begin
            exp_err = 1'b1;
        end
        if (!oe) exp_err = 1'b1;
        tick();
        checks++;
        if (wr_done !== 1'b0) begin
            errors++; $display("FAIL wr_done_width: got %b expected 0", wr_done);
        end
        checks++;
        if (err !== exp_err) begin
            errors++; $display("FAIL err_after_write: got %b expected %b", err, exp_err);
        end
    endtask

    task automatic do_read(input logic [22:0] addr, input logic lb, input logic ub, input int n);
        logic [15:0] exp;
        logic [15:0] got;
        exp = model[addr[9:0]];
        if (lb) exp[7:0]  = 8'h00;
        if (ub) exp[15:8] = 8'h00;
        if (n >= RL) exp_q.push_back(exp);
        ce_x = 1'b0; oe_x = 1'b0; we_x = 1'b1;
        a_in = addr; lb_x = lb; ub_x = ub; tb_oe = 1'b0;
        for (int k = 1; k <= n; k++) begin
            tick();
            checks++;
            if (rd_done !== (k == RL)) begin
                errors++; $display("FAIL rd_done: cycle %0d got %b expected %b", k, rd_done, k == RL);
            end
            if (rd_done === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rd_unexpected: rd_done with no pending read");
                end else begin
                    got = exp_q.pop_front();
                    if (dq !== got) begin
                        errors++; $display("FAIL rd_data: addr %h got %h expected %h", addr, dq, got);
                    end
                end
            end else if (k < RL) begin
                checks++;
                if (dq !== RELEASED) begin
                    errors++; $display("FAIL dq_early: cycle %0d got %h expected released", k, dq);
                end
            end else begin
                checks++;
                if (dq !== exp) begin
                    errors++; $display("FAIL dq_hold: cycle %0d got %h expected %h", k, dq, exp);
                end
            end
        end
        ce_x = 1'b1; oe_x = 1'b1;
        tick();
        checks++;
        if (dq !== RELEASED || rd_done !== 1'b0) begin
            errors++; $display("FAIL dq_release: dq %h rd_done %b expected released/0", dq, rd_done);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rd_missing: %0d reads never completed", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        bus_idle();
        a_in = '0; tb_dq = '0; rst = 1'b1; exp_err = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (dq !== RELEASED || wr_done !== 1'b0 || rd_done !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: cycle %0d dq %h wr %b rd %b err %b expected released/0/0/0",
                         i, dq, wr_done, rd_done, err);
            end
        end
    endtask

    task automatic test_write_read();
        do_write(23'h000012, 16'hA5C3, 1'b0, 1'b0, 1'b1, 2);
        do_read(23'h000012, 1'b0, 1'b0, 3);
        do_read(23'h400012, 1'b0, 1'b0, 2);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_clean: got %b expected 0", err);
        end
    endtask

    task automatic test_byte_lanes();
        do_write(23'd5, 16'hFFFF, 1'b0, 1'b0, 1'b1, 2);
        do_write(23'd5, 16'h1200, 1'b1, 1'b0, 1'b1, 3);
        checks++;
        if (model[5] !== 16'h12FF) begin
            errors++; $display("FAIL lane_model: got %h expected 12ff", model[5]);
        end
        do_read(23'd5, 1'b0, 1'b0, 3);
        do_read(23'd5, 1'b1, 1'b0, 2);
        do_read(23'd5, 1'b0, 1'b1, 4);
    endtask

    task automatic test_short_read();
        do_read(23'h000012, 1'b0, 1'b0, 1);
    endtask

    task automatic test_addr_track();
        logic [15:0] got;
        do_write(23'h000020, 16'h4242, 1'b0, 1'b0, 1'b1, 2);
        exp_q.push_back(model[10'h012]);
        ce_x = 1'b0; oe_x = 1'b0; we_x = 1'b1; a_in = 23'h000012; lb_x = 1'b0; ub_x = 1'b0;
        tick();
        tick();
        checks++;
        if (rd_done !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL track_rd_done: got %b expected 1", rd_done);
        end else begin
            got = exp_q.pop_front();
            if (dq !== got) begin
                errors++; $display("FAIL track_first: got %h expected %h", dq, got);
            end
        end
        a_in = 23'h000020;
        tick();
        checks++;
        if (dq !== model[10'h020]) begin
            errors++; $display("FAIL track_new_addr: got %h expected %h", dq, model[10'h020]);
        end
        bus_idle();
        tick();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_write();
        do_write(23'd0, 16'h3333, 1'b0, 1'b0, 1'b1, 2);
        ce_x = 1'b0; we_x = 1'b0; oe_x = 1'b1; a_in = '0; tb_dq = 16'hDEAD; tb_oe = 1'b1;
        tick();
        rst = 1'b1;
        bus_idle();
        tick();
        rst = 1'b0;
        checks++;
        if (wr_done !== 1'b0 || err !== 1'b0 || dq !== RELEASED) begin
            errors++; $display("FAIL rst_abort: wr %b err %b dq %h expected 0/0/released", wr_done, err, dq);
        end
        tick();
        checks++;
        if (wr_done !== 1'b0) begin
            errors++; $display("FAIL rst_no_commit: got %b expected 0", wr_done);
        end
        exp_err = 1'b0;
        do_read(23'd0, 1'b0, 1'b0, 3);
        do_write(23'd0, 16'h0F0F, 1'b0, 1'b0, 1'b1, 2);
        do_read(23'd0, 1'b0, 1'b0, 3);
    endtask

    task automatic test_we_oe_conflict();
        do_write(23'd9, 16'h7777, 1'b0, 1'b0, 1'b0, 2);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_err = 1'b0;
        tick();
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_cleared_by_rst: got %b expected 0", err);
        end
        do_read(23'd9, 1'b0, 1'b0, 3);
    endtask

    task automatic test_short_write();
        do_write(23'd7, 16'h1111, 1'b0, 1'b0, 1'b1, 2);
        do_write(23'd7, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (err !== 1'b1) begin
                errors++; $display("FAIL err_sticky: cycle %0d got %b expected 1", i, err);
            end
        end
        do_read(23'd7, 1'b0, 1'b0, 3);
        do_write(23'd7, 16'h2222, 1'b0, 1'b0, 1'b1, 4);
        do_read(23'd7, 1'b0, 1'b0, 2);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_short_read();
        test_addr_track();
        test_reset_mid_write();
        test_we_oe_conflict();
        test_short_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
